// File: rtl/sd_match_logger_if.sv
`default_nettype none
// ============================================================================
// Module      : sd_match_logger_if
// Description : Bundle of the match input, flush control, FIFO read port and
//               status outputs of sd_match_logger. The master side drives op,
//               clear and rd_ready; the slave side (the logger) drives the
//               read data and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface sd_match_logger_if #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16,
    parameter int CNT_W = 8
);
    localparam int c_lvl_w = $clog2(DEPTH) + 1;

    logic               op;
    logic               clear;
    logic               rd_ready;
    logic               rd_valid;
    logic [TS_W-1:0]    rd_data;
    logic [CNT_W-1:0]   match_count;
    logic               overflow;
    logic [c_lvl_w-1:0] fifo_level;

    modport master (
        output op, clear, rd_ready,
        input  rd_valid, rd_data, match_count, overflow, fifo_level
    );

    modport slave (
        input  op, clear, rd_ready,
        output rd_valid, rd_data, match_count, overflow, fifo_level
    );
endinterface
`default_nettype wire

// File: rtl/sd_match_logger.sv
`default_nettype none
// ============================================================================
// Module      : sd_match_logger
// Description : Timestamps every cycle the detector's match pulse is high
//               against a free-running wrapping counter and queues the stamps
//               in a show-ahead FIFO drained through a valid/ready port.
//               Also keeps a saturating match count and a sticky overflow
//               flag. Optional macro SD_LOG_DROP_OLDEST_EN: when defined, a
//               push into a full FIFO without a same-cycle pop evicts the
//               oldest entry; otherwise the new event is discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_match_logger #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16,
    parameter int CNT_W = 8
) (
    input  wire                  clk,
    input  wire                  areset,
    sd_match_logger_if.slave     bus
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;
    localparam logic [c_lvl_w-1:0] c_full    = c_lvl_w'(DEPTH);
    localparam logic [c_lvl_w-1:0] c_lvl_one = c_lvl_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [CNT_W-1:0]   c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   c_cnt_one = CNT_W'(1);
    localparam logic [TS_W-1:0]    c_ts_one  = TS_W'(1);

    logic [TS_W-1:0]    r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_lvl_w-1:0] r_level;
    logic [TS_W-1:0]    r_ts;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic w_ovf_evt;
    logic w_write;
    logic w_drop;
    logic w_adv_rd;
    logic w_inc;
    logic w_dec;

    // A clear cycle swallows both the event and any read request.
    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == c_full);
    assign w_push    = bus.op & ~bus.clear;
    assign w_pop     = ~w_empty & bus.rd_ready & ~bus.clear;
    // A same-cycle pop frees a slot, so only a push without pop can overflow.
    assign w_ovf_evt = w_push & w_full & ~w_pop;

`ifdef SD_LOG_DROP_OLDEST_EN
    // Overflowing push still writes; the head is evicted to make room.
    assign w_write = w_push;
    assign w_drop  = w_ovf_evt;
`else
    // Overflowing push is discarded; FIFO contents stay untouched.
    assign w_write = w_push & ~w_ovf_evt;
    assign w_drop  = 1'b0;
`endif

    assign w_adv_rd = w_pop | w_drop;
    // Evictions always coincide with a write, so they never change the level.
    assign w_inc    = w_write & ~w_adv_rd;
    assign w_dec    = w_adv_rd & ~w_write;

    assign bus.rd_valid    = ~w_empty;
    assign bus.rd_data     = r_mem[r_rd_ptr];
    assign bus.match_count = r_cnt;
    assign bus.overflow    = r_ovf;
    assign bus.fifo_level  = r_level;

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= r_ts;
        end
    end

    // Pointers and occupancy; pointer widths make wrap-around implicit.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else if (bus.clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_adv_rd) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_inc) begin
                r_level <= r_level + c_lvl_one;
            end else if (w_dec) begin
                r_level <= r_level - c_lvl_one;
            end
        end
    end

    // Free-running timestamp; the value held before an edge is what gets logged.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_ts <= '0;
        end else if (bus.clear) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + c_ts_one;
        end
    end

    // Saturating event count and sticky overflow, both counting dropped events.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (bus.clear) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_push && (r_cnt != c_cnt_max)) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sd_match_logger.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_match_logger
// Description : Self-checking bench for sd_match_logger. Two instances run on
//               the same stimulus: a default-sized one and a narrow one
//               (DEPTH=4, TS_W=4, CNT_W=4) for counter saturation and
//               timestamp wrap. A queue-based model predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_match_logger;
    logic clk = 1'b0;
    logic areset = 1'b1;
    logic s_op = 1'b0;
    logic s_clear = 1'b0;
    logic s_rdy = 1'b0;
    bit   chk_en = 1'b0;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sd_match_logger_if #(.DEPTH(8), .TS_W(16), .CNT_W(8)) bus_a ();
    sd_match_logger_if #(.DEPTH(4), .TS_W(4),  .CNT_W(4)) bus_b ();

    assign bus_a.op = s_op;
    assign bus_a.clear = s_clear;
    assign bus_a.rd_ready = s_rdy;
    assign bus_b.op = s_op;
    assign bus_b.clear = s_clear;
    assign bus_b.rd_ready = s_rdy;

    sd_match_logger #(.DEPTH(8), .TS_W(16), .CNT_W(8)) dut_a (
        .clk(clk), .areset(areset), .bus(bus_a.slave));
    sd_match_logger #(.DEPTH(4), .TS_W(4), .CNT_W(4)) dut_b (
        .clk(clk), .areset(areset), .bus(bus_b.slave));

    // ---------------- behavioural model ----------------
    int q0[$];
    int q1[$];
    int m_ts[2];
    int m_cnt[2];
    int m_ovf[2];

    function automatic int dep(int k);   return (k == 0) ? 8 : 4; endfunction
    function automatic int tsmod(int k); return (k == 0) ? 65536 : 16; endfunction
    function automatic int cmax(int k);  return (k == 0) ? 255 : 15; endfunction
    function automatic int msize(int k); return (k == 0) ? q0.size() : q1.size(); endfunction

    task automatic mpush(int k, int v);
        if (k == 0) q0.push_back(v); else q1.push_back(v);
    endtask
    task automatic mpop(int k);
        int d;
        if (k == 0) d = q0.pop_front(); else d = q1.pop_front();
    endtask
    task automatic model_reset(int k);
        if (k == 0) q0.delete(); else q1.delete();
        m_ts[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
    endtask

    task automatic model_step(int k, bit o, bit c, bit r);
        if (c) begin
            model_reset(k);
            return;
        end
        if (msize(k) > 0 && r) mpop(k);
        if (o) begin
            if (msize(k) < dep(k)) begin
                mpush(k, m_ts[k]);
            end else begin
                m_ovf[k] = 1;
`ifdef SD_LOG_DROP_OLDEST_EN
                mpop(k);
                mpush(k, m_ts[k]);
`endif
            end
            if (m_cnt[k] < cmax(k)) m_cnt[k]++;
        end
        m_ts[k] = (m_ts[k] + 1) % tsmod(k);
    endtask

    // ---------------- checking ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("a.rd_valid", 32'(bus_a.rd_valid), 32'(q0.size() > 0));
            if (q0.size() > 0) check("a.rd_data", 32'(bus_a.rd_data), q0[0]);
            check("a.fifo_level", 32'(bus_a.fifo_level), q0.size());
            check("a.match_count", 32'(bus_a.match_count), m_cnt[0]);
            check("a.overflow", 32'(bus_a.overflow), m_ovf[0]);
            check("b.rd_valid", 32'(bus_b.rd_valid), 32'(q1.size() > 0));
            if (q1.size() > 0) check("b.rd_data", 32'(bus_b.rd_data), q1[0]);
            check("b.fifo_level", 32'(bus_b.fifo_level), q1.size());
            check("b.match_count", 32'(bus_b.match_count), m_cnt[1]);
            check("b.overflow", 32'(bus_b.overflow), m_ovf[1]);
        end
    end

    // One clock cycle with the given inputs; returns at the following negedge.
    task automatic step(bit o, bit c, bit r);
        s_op = o; s_clear = c; s_rdy = r;
        @(posedge clk);
        if (areset) begin
            model_reset(0); model_reset(1);
        end else begin
            model_step(0, o, c, r); model_step(1, o, c, r);
        end
        @(negedge clk);
    endtask

    // Asynchronous reset between edges, held for two edges.
    task automatic async_reset();
        #2;
        areset = 1'b1;
        model_reset(0); model_reset(1);
        #1;
        check("async rd_valid", 32'(bus_a.rd_valid), 0);
        check("async fifo_level", 32'(bus_a.fifo_level), 0);
        check("async match_count", 32'(bus_a.match_count), 0);
        @(negedge clk);
        step(0, 0, 0);
        step(0, 0, 0);
        areset = 1'b0;
    endtask

    initial begin
        int rdp;
        model_reset(0); model_reset(1);
        // Reset held for two edges
        @(negedge clk);
        step(0, 0, 0);
        step(0, 0, 0);
        chk_en = 1'b1;
        check("reset rd_valid", 32'(bus_a.rd_valid), 0);
        check("reset fifo_level", 32'(bus_a.fifo_level), 0);
        check("reset match_count", 32'(bus_a.match_count), 0);
        check("reset overflow", 32'(bus_a.overflow), 0);
        areset = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        check("first rd_data", 32'(bus_a.rd_data), 2);
        check("first rd_valid", 32'(bus_a.rd_valid), 1);
        check("first fifo_level", 32'(bus_a.fifo_level), 1);
        check("first match_count", 32'(bus_a.match_count), 1);

        // Ordering and back-to-back drain
        step(0, 1, 0);
        for (int i = 0; i < 20; i++) step(i == 5 || i == 9 || i == 12, 0, 0);
        check("order head0", 32'(bus_a.rd_data), 5);
        step(0, 0, 1);
        check("order head1", 32'(bus_a.rd_data), 9);
        step(0, 0, 1);
        check("order head2", 32'(bus_a.rd_data), 12);
        step(0, 0, 1);
        check("order drained", 32'(bus_a.rd_valid), 0);
        check("order overflow", 32'(bus_a.overflow), 0);

        // Overflow with no reads: events at ts 1..9
        step(0, 1, 0);
        step(0, 0, 0);
        for (int i = 1; i <= 9; i++) step(1, 0, 0);
        check("ovf level", 32'(bus_a.fifo_level), 8);
        check("ovf flag", 32'(bus_a.overflow), 1);
        check("ovf count", 32'(bus_a.match_count), 9);
`ifdef SD_LOG_DROP_OLDEST_EN
        check("ovf head", 32'(bus_a.rd_data), 2);
`else
        check("ovf head", 32'(bus_a.rd_data), 1);
`endif

        // Full FIFO with simultaneous push and pop
        step(0, 1, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 0);
        step(1, 0, 1);
        check("fullpp level", 32'(bus_a.fifo_level), 8);
        check("fullpp overflow", 32'(bus_a.overflow), 0);
        for (int i = 1; i <= 8; i++) begin
            check("fullpp drain", 32'(bus_a.rd_data), i);
            step(0, 0, 1);
        end
        check("fullpp empty", 32'(bus_a.rd_valid), 0);

        // Timestamp wrap and counter saturation on the narrow instance
        step(0, 1, 0);
        for (int i = 0; i <= 16; i++) step(i >= 15, 0, 0);
        check("wrap b head", 32'(bus_b.rd_data), 15);
        step(0, 0, 1);
        check("wrap b next", 32'(bus_b.rd_data), 0);
        check("wrap a next", 32'(bus_a.rd_data), 16);
        step(0, 1, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 1);
        check("sat b count", 32'(bus_b.match_count), 15);
        check("sat a count", 32'(bus_a.match_count), 20);

        // Clear together with an event on a non-empty FIFO
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        step(1, 1, 1);
        check("clear level", 32'(bus_a.fifo_level), 0);
        check("clear count", 32'(bus_a.match_count), 0);
        check("clear overflow", 32'(bus_a.overflow), 0);
        check("clear valid", 32'(bus_a.rd_valid), 0);
        step(1, 0, 0);
        check("post-clear ts", 32'(bus_a.rd_data), 0);
        check("post-clear level", 32'(bus_a.fifo_level), 1);

        // Mid-operation asynchronous reset
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        async_reset();

        // Randomized traffic with varying read pressure
        rdp = 50;
        for (int n = 0; n < 4000; n++) begin
            if (n % 200 == 0) rdp = $urandom_range(100);
            if ($urandom_range(599) == 0) async_reset();
            step($urandom_range(99) < 50, $urandom_range(199) == 0,
                 $urandom_range(99) < rdp);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sd_match_logger.md
# sd_match_logger

Downstream consumer of the sequence detector's one-cycle match output `op`. It timestamps every match against a free-running cycle counter and buffers the timestamps in a small FIFO. A valid/ready read port drains the FIFO. The block also keeps a saturating match count and a sticky overflow flag, so a host or bench can audit detector activity without sampling `op` every cycle.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `TS_W`, 16: timestamp width in bits.
- `CNT_W`, 8: match counter width in bits.

- `clk`  input  1  single clock; all state updates on its rising edge.
- `areset`  input  1  asynchronous, active-high reset.
- `op`  input  1  match pulse from the detector; each cycle sampled high is one event.
- `clear`  input  1  synchronous flush of FIFO, counters and flags.
- `rd_ready`  input  1  consumer accepts `rd_data` this cycle.
- `rd_valid`  output  1  FIFO non-empty.
- `rd_data`  output  TS_W  timestamp at FIFO head.
- `match_count`  output  CNT_W  saturating count of accepted `op` events.
- `overflow`  output  1  sticky; set when an event hits a full FIFO.
- `fifo_level`  output  $clog2(DEPTH)+1  current occupancy.

## Operation
- Timestamp counter `ts`:
  - Increments every cycle and wraps from 2^TS_W-1 to 0.
  - An event logs the value of `ts` held before the edge that samples `op`=1.
- Push and pop:
  - Push: `op`=1 and `clear`=0.
  - Pop: `rd_valid`=1 and `rd_ready`=1. `rd_ready` while empty is ignored.
- FIFO:
  - Show-ahead. `rd_data` = mem[rd_ptr] combinationally, and is held stable while `rd_valid`=1 and `rd_ready`=0.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- Occupancy:
  - Full means `fifo_level`=DEPTH.
  - Empty means `fifo_level`=0; then `rd_valid`=0 and `rd_data` is don't-care.
- `match_count`:
  - Increments on every push, including pushes that overflow.
  - Saturates at 2^CNT_W-1 and never wraps.
- Push on full FIFO without a same-cycle pop: behaviour is set by the Configuration macro, and `overflow` sets to 1.
- Push and pop in the same cycle:
  - Level is unchanged.
  - Allowed when full; no overflow.
  - Never occurs when empty, because `rd_valid`=0, so there is no bypass.
- `clear`=1:
  - Next edge sets pointers, `fifo_level`, `ts`, `match_count` and `overflow` to 0.
  - Wins over a same-cycle push and pop; that event is dropped and not counted.
- `areset`: asynchronously forces the same state as `clear`.
- Reset values: `rd_valid`=0, `fifo_level`=0, `match_count`=0, `overflow`=0, `ts`=0. `rd_data` is undefined until the first push.

## Timing
- Push to visibility: an event sampled at edge N sets `rd_valid`=1 and updates `fifo_level` after edge N.
- Pop: takes effect at the edge where `rd_valid`=1 and `rd_ready`=1. The next entry appears after that edge; there is no bubble between back-to-back pops.
- Throughput: one push and one pop per cycle sustained.
- Reset:
  - Assertion of `areset` mid-operation discards contents immediately, without waiting for a clock edge.
  - Deassertion: the first edge after release has `ts`=0.
- `match_count` and `overflow` update on the same edge as the push.

## Configuration
- `SD_LOG_DROP_OLDEST_EN` defined: a push on full without pop discards the head entry, advances `rd_ptr` and writes the new timestamp. `fifo_level` stays DEPTH; the FIFO keeps the newest DEPTH events.
- Macro undefined (default): a push on full without pop leaves the FIFO untouched; the new event is dropped. `match_count` still increments in both modes.

## Test plan
- Reset check: assert `areset` for 2 cycles, then release.
  - All outputs at reset values.
  - First `op` pulse at the 3rd edge after release -> `rd_data`=2, `rd_valid`=1, `fifo_level`=1, `match_count`=1.
- Ordering and back-to-back drain: pulses at timestamps 5, 9 and 12, with `rd_ready`=1 held from cycle 20.
  - `rd_data` reads 5, 9, 12 on consecutive cycles.
  - `rd_valid` drops after the third pop; `overflow`=0.
- Overflow, DEPTH=8, `rd_ready`=0: push 9 events at ts 1..9.
  - Default: `fifo_level`=8, `overflow`=1, `match_count`=9, head=1.
  - `SD_LOG_DROP_OLDEST_EN`: head=2, tail=9.
- Full with simultaneous push and pop: FIFO full, then `op`=1 and `rd_ready`=1 in the same cycle.
  - Level stays 8, `overflow` stays 0.
  - Popped entry is the old head; the new timestamp lands at the tail.
- Saturation and wrap, CNT_W=4, TS_W=4:
  - 20 pushes -> `match_count`=15.
  - Event at ts=15 followed by event at ts=0 -> stored values 15 then 0.
- Clear: assert `clear` together with `op` on a non-empty FIFO.
  - Next cycle: `fifo_level`=0, `match_count`=0, `overflow`=0.
  - The same-cycle event is absent.
  - Next push logs ts=0 or later, counted from the clear edge.
